sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//  Downstream consumer of the 4-bit ripple adder's 5-bit sum output.
//  - Accepts one sum per valid/ready handshake and accumulates NUM_SAMPLES sums into a wider register.
//  - Presents the total on a valid/ready output port, with a sticky overflow flag.
//  - Sits between the adder array and the result-collection logic.
// PARAMETERS
//  IN_W         5  width of each incoming sum; matches the adder's {carry,sum[3:0]}
//  ACC_W        8  accumulator/result width; must be >= IN_W
//  NUM_SAMPLES  4  sums per accumulation frame; must be >= 2
// PORTS
//  clk        in   1       sole clock; all state updates on the rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  clear      in   1       synchronous abort of the current frame
//  in_sum     in   IN_W    sum from the adder stage; unsigned
//  in_valid   in   1       in_sum is valid
//  in_ready   out  1       block can accept in_sum
//  out_sum    out  ACC_W   accumulated frame total
//  out_ovf    out  1       frame total exceeded 2^ACC_W-1
//  out_valid  out  1       out_sum/out_ovf are valid
//  out_ready  in   1       downstream accepts the result
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, acc=0, cnt=0, out_valid=0, out_ovf=0, out_sum=0.
//    in_ready=1 once rst_n deasserts.
//  - in_ready = (state!=DONE). Transfer = in_valid & in_ready. No input is accepted while DONE.
//  - FSM states:
//    - IDLE: on transfer, acc<=in_sum (zero-extended), cnt<=1, ovf<=0; go to ACCUM.
//    - ACCUM: on transfer, acc<=acc+in_sum, cnt<=cnt+1. If cnt==NUM_SAMPLES-1, go to DONE.
//      No transfer: hold. in_valid gaps are allowed and do not change acc.
//    - DONE: out_valid=1, out_sum=acc, out_ovf=sticky ovf. Held stable while out_ready=0.
//      On out_ready=1, go to IDLE. acc, cnt and ovf clear in the same edge.
//  - Latency: out_valid rises on the cycle after the NUM_SAMPLES-th accepted transfer.
//    Back-to-back frames lose exactly one input cycle (the DONE handshake cycle).
//  - Arithmetic: unsigned. The add is computed ACC_W+1 wide. A carry out of bit ACC_W-1 sets
//    the sticky ovf bit.
//  - clear=1 has priority over every transfer and over reset-free state:
//    - Next state IDLE; acc, cnt and ovf go to 0; out_valid goes low.
//    - An in_sum presented in the same cycle is dropped.
//  - out_sum/out_ovf equal 0 whenever out_valid=0.
//  - cnt width is $clog2(NUM_SAMPLES+1). cnt never wraps, because the FSM leaves ACCUM at the limit.
// CONFIGURATION
//  SUM_ACC_SATURATE_EN defined:
//    - On overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the frame.
//    - out_ovf is set.
//  Not defined: acc wraps modulo 2^ACC_W; out_ovf is still set.
//  Handshake, latency and FSM are identical in both builds.
// STRUCTURE
//  - Package sum_acc_pkg holds: the state typedef {IDLE, ACCUM, DONE}, default widths
//    IN_W/ACC_W, and the function cnt_w(NUM_SAMPLES).
//  - Sub-module acc_add_sat is combinational:
//    - Inputs: acc, zero-extended in_sum.
//    - Outputs: next_acc, carry.
//    - Contains the SUM_ACC_SATURATE_EN clamp.
//  - The top level holds the FSM, the counter and the output registers.
// TESTING (defaults unless stated)
//  1. Basic frame: sums 3,5,7,9 on consecutive cycles, out_ready=1 -> out_valid=1 for one cycle
//     after the 4th transfer; out_sum=24, out_ovf=0; back in IDLE.
//  2. Backpressure: frame of 31,31,31,31 with out_ready=0 for 5 cycles -> out_sum=124 held stable,
//     in_ready=0 throughout; releases on the 1st cycle with out_ready=1.
//  3. Input gaps: 1,_,2,_,_,3,4 (_ = in_valid low) -> out_sum=10; acc unchanged during gaps.
//  4. Overflow, ACC_W=6, sums 31,31,31,31 -> out_ovf=1.
//     out_sum=60 without SUM_ACC_SATURATE_EN; out_sum=63 with it.
//  5. Clear: accept 10,10, then clear=1 with in_valid=1 (in_sum=7) -> that sum is dropped.
//     Following frame 1,1,1,1 -> out_sum=4.
//  6. Async reset: assert rst_n=0 mid-frame after two sums, and again while in DONE ->
//     all outputs 0 immediately; next full frame 2,2,2,2 -> out_sum=8.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// Shared types, default widths and helpers for the sum accumulator.
package sum_acc_pkg;

   localparam int unsigned DEF_IN_W  = 5;
   localparam int unsigned DEF_ACC_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter must hold the value NUM_SAMPLES itself.
   function automatic int unsigned cnt_w(input int unsigned num_samples);
      return $clog2(num_samples + 1);
   endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Combinational accumulate step with carry detect.
// With SUM_ACC_SATURATE_EN defined the result clamps to all-ones on carry.
module acc_add_sat
   import sum_acc_pkg::*;
#(
   parameter int unsigned ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] addend,
   output logic [ACC_W-1:0] next_acc,
   output logic             carry
);

   logic [ACC_W:0] sum_w;

   always_comb begin
      sum_w = {1'b0, acc} + {1'b0, addend};
      carry = sum_w[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
      next_acc = carry ? '1 : sum_w[ACC_W-1:0];
`else
      next_acc = sum_w[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES adder sums per frame and presents the total with a sticky overflow.
// Optional build macro: SUM_ACC_SATURATE_EN (clamp instead of wrap, in acc_add_sat).
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int unsigned IN_W        = DEF_IN_W,
   parameter int unsigned ACC_W       = DEF_ACC_W,
   parameter int unsigned NUM_SAMPLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [IN_W-1:0]  in_sum,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned CNT_W = cnt_w(NUM_SAMPLES);

   state_t             state, state_nx;
   logic [ACC_W-1:0]   acc, acc_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               ovf, ovf_nx;
   logic [ACC_W-1:0]   out_sum_nx;
   logic               out_ovf_nx, out_valid_nx;
   logic [ACC_W-1:0]   add_acc;
   logic               add_carry;
   logic               xfer;

   assign in_ready = (state != DONE);
   assign xfer     = in_valid & in_ready;

   acc_add_sat #(.ACC_W(ACC_W)) u_add (
      .acc      (acc),
      .addend   (ACC_W'(in_sum)),
      .next_acc (add_acc),
      .carry    (add_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         acc       <= acc_nx;
         cnt       <= cnt_nx;
         ovf       <= ovf_nx;
         out_sum   <= out_sum_nx;
         out_ovf   <= out_ovf_nx;
         out_valid <= out_valid_nx;
      end
   end

   // Next state; result registers are loaded on entry to DONE and zero elsewhere.
   always_comb begin
      state_nx     = state;
      acc_nx       = acc;
      cnt_nx       = cnt;
      ovf_nx       = ovf;
      out_sum_nx   = '0;
      out_ovf_nx   = 1'b0;
      out_valid_nx = 1'b0;

      if (clear) begin
         state_nx = IDLE;
         acc_nx   = '0;
         cnt_nx   = '0;
         ovf_nx   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  acc_nx   = ACC_W'(in_sum);
                  cnt_nx   = CNT_W'(1);
                  ovf_nx   = 1'b0;
                  state_nx = ACCUM;
               end
            end
            ACCUM: begin
               if (xfer) begin
                  acc_nx = add_acc;
                  cnt_nx = cnt + CNT_W'(1);
                  ovf_nx = ovf | add_carry;
                  if (cnt == CNT_W'(NUM_SAMPLES - 1)) begin
                     state_nx     = DONE;
                     out_valid_nx = 1'b1;
                     out_sum_nx   = add_acc;
                     out_ovf_nx   = ovf | add_carry;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_nx = IDLE;
                  acc_nx   = '0;
                  cnt_nx   = '0;
                  ovf_nx   = 1'b0;
               end else begin
                  out_valid_nx = 1'b1;
                  out_sum_nx   = out_sum;
                  out_ovf_nx   = out_ovf;
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: frame table plus multi-cycle corner sequences.
module tb_sum_accumulator;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic [4:0] in_sum;
   logic       in_valid;
   logic       in_ready, in_ready6;
   logic [7:0] out_sum;
   logic [5:0] out_sum6;
   logic       out_ovf, out_ovf6;
   logic       out_valid, out_valid6;
   logic       out_ready;

   int n_cmp = 0;
   int n_err = 0;

   sum_accumulator #(.IN_W(5), .ACC_W(8), .NUM_SAMPLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_sum(in_sum), .in_valid(in_valid),
      .in_ready(in_ready), .out_sum(out_sum), .out_ovf(out_ovf), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   // Narrow accumulator sharing the same stimulus, used for overflow checks.
   sum_accumulator #(.IN_W(5), .ACC_W(6), .NUM_SAMPLES(4)) dut6 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_sum(in_sum), .in_valid(in_valid),
      .in_ready(in_ready6), .out_sum(out_sum6), .out_ovf(out_ovf6), .out_valid(out_valid6),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int s0, s1, s2, s3;
      int exp_sum;
   } frame_t;

   frame_t frames[5];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int a, input int b, input int c, input int d);
      int v[4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         chk("in_ready_during_frame", int'(in_ready), 1);
         chk("out_valid_during_frame", int'(out_valid), 0);
         in_valid = 1'b1;
         in_sum   = 5'(v[i]);
         tick();
      end
      in_valid = 1'b0;
      in_sum   = 5'd0;
   endtask

   task automatic check_done(input int exp);
      chk("out_valid_done", int'(out_valid), 1);
      chk("out_sum_done", int'(out_sum), exp);
      chk("out_ovf_done", int'(out_ovf), 0);
      chk("in_ready_done", int'(in_ready), 0);
   endtask

   task automatic release_done();
      out_ready = 1'b1;
      tick();
      chk("out_valid_after_release", int'(out_valid), 0);
      chk("out_sum_after_release", int'(out_sum), 0);
      chk("in_ready_after_release", int'(in_ready), 1);
   endtask

   initial begin
      frames[0] = '{s0: 3,  s1: 5,  s2: 7,  s3: 9,  exp_sum: 24};
      frames[1] = '{s0: 31, s1: 31, s2: 31, s3: 31, exp_sum: 124};
      frames[2] = '{s0: 0,  s1: 0,  s2: 0,  s3: 0,  exp_sum: 0};
      frames[3] = '{s0: 31, s1: 31, s2: 31, s3: 30, exp_sum: 123};
      frames[4] = '{s0: 1,  s1: 2,  s2: 4,  s3: 8,  exp_sum: 15};

      rst_n = 1'b0; clear = 1'b0; in_sum = '0; in_valid = 1'b0; out_ready = 1'b1;
      #12;
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_sum", int'(out_sum), 0);
      chk("reset_out_ovf", int'(out_ovf), 0);
      rst_n = 1'b1;
      tick();
      chk("reset_in_ready", int'(in_ready), 1);

      // Frame table, including the basic 3,5,7,9 frame.
      for (int f = 0; f < 5; f++) begin
         feed(frames[f].s0, frames[f].s1, frames[f].s2, frames[f].s3);
         check_done(frames[f].exp_sum);
         release_done();
      end

      // Backpressure: result held while out_ready low, inputs offered are ignored.
      out_ready = 1'b0;
      feed(31, 31, 31, 31);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_sum   = 5'd5;
         check_done(124);
         tick();
      end
      in_valid = 1'b0;
      check_done(124);
      release_done();
      feed(1, 1, 1, 1);
      check_done(4);
      release_done();

      // Input gaps: 1,_,2,_,_,3,4.
      begin
         int gv[7];
         int gs[7];
         gv = '{1, 0, 1, 0, 0, 1, 1};
         gs = '{1, 31, 2, 17, 31, 3, 4};
         for (int i = 0; i < 7; i++) begin
            chk("gap_out_valid_low", int'(out_valid), 0);
            in_valid = gv[i][0];
            in_sum   = 5'(gs[i]);
            tick();
         end
         in_valid = 1'b0;
         check_done(10);
         release_done();
      end

      // Overflow on the 6-bit instance.
      out_ready = 1'b0;
      feed(31, 31, 31, 31);
      check_done(124);
      chk("ovf6_out_valid", int'(out_valid6), 1);
      chk("ovf6_out_ovf", int'(out_ovf6), 1);
`ifdef SUM_ACC_SATURATE_EN
      chk("ovf6_out_sum", int'(out_sum6), 63);
`else
      chk("ovf6_out_sum", int'(out_sum6), 60);
`endif
      tick();
      chk("ovf6_held_ovf", int'(out_ovf6), 1);
      release_done();
      chk("ovf6_cleared_ovf", int'(out_ovf6), 0);
      chk("ovf6_cleared_sum", int'(out_sum6), 0);

      // Clear mid-frame drops the concurrent sum.
      in_valid = 1'b1; in_sum = 5'd10; tick();
      in_sum = 5'd10; tick();
      clear = 1'b1; in_sum = 5'd7; tick();
      clear = 1'b0; in_valid = 1'b0;
      chk("clear_out_valid", int'(out_valid), 0);
      chk("clear_in_ready", int'(in_ready), 1);
      feed(1, 1, 1, 1);
      check_done(4);
      release_done();

      // Clear while DONE with backpressure.
      out_ready = 1'b0;
      feed(2, 3, 4, 5);
      check_done(14);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clear_done_out_valid", int'(out_valid), 0);
      chk("clear_done_out_sum", int'(out_sum), 0);
      chk("clear_done_in_ready", int'(in_ready), 1);
      out_ready = 1'b1;

      // Async reset mid-frame, then again while DONE.
      in_valid = 1'b1; in_sum = 5'd9; tick();
      in_sum = 5'd9; tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", int'(out_valid), 0);
      chk("rst_mid_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      tick();
      out_ready = 1'b0;
      feed(6, 6, 6, 6);
      check_done(24);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_done_out_valid", int'(out_valid), 0);
      chk("rst_done_out_sum", int'(out_sum), 0);
      chk("rst_done_out_ovf", int'(out_ovf), 0);
      chk("rst_done_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      feed(2, 2, 2, 2);
      check_done(8);
      release_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
